// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit bundle: register indices and controls in,
// forwarding selects, stall/flush and multi-cycle status out.
interface hazard_unit_if;
  logic [4:0] rs1D, rs2D;
  logic [4:0] rs1E, rs2E, rdE;
  logic [1:0] ResultSrcE;
  logic       PCSrcE;
  logic       MdValidE;
  logic [4:0] rdM;
  logic       RegWriteM;
  logic [4:0] rdW;
  logic       RegWriteW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE;
  logic       FlushD, FlushE;
  logic       MdStartE, MdDoneE, MdBusyE;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, ResultSrcE, PCSrcE, MdValidE,
           rdM, RegWriteM, rdW, RegWriteW,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
           MdStartE, MdDoneE, MdBusyE
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, ResultSrcE, PCSrcE, MdValidE,
           rdM, RegWriteM, rdW, RegWriteW,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
           MdStartE, MdDoneE, MdBusyE
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush
// and a multi-cycle (mul/div) occupancy sequencer that holds E.
//
// state | meaning
// IDLE  | no multi-cycle op in E; a new MdValidE starts one
// BUSY  | op in flight; cnt counts down to its final cycle (cnt==1)
module hazard_unit #(
  parameter int MD_LATENCY = 4
) (
  input logic          clk,
  input logic          reset,
  hazard_unit_if.slave hz
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] CNT_START = 4'(MD_LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       lw_stall;
  logic       md_stall;
  logic       md_start;
  logic       md_done;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m,
                                         input logic [4:0] rd_m,
                                         input logic       wr_w,
                                         input logic [4:0] rd_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    else                                              return 2'b00;
  endfunction

  always_comb begin
    hz.ForwardAE = fwd_sel(hz.rs1E, hz.RegWriteM, hz.rdM, hz.RegWriteW, hz.rdW);
    hz.ForwardBE = fwd_sel(hz.rs2E, hz.RegWriteM, hz.rdM, hz.RegWriteW, hz.rdW);
  end

  always_comb begin
    lw_stall = (hz.ResultSrcE == 2'b01) && (hz.rdE != 5'd0) &&
               ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
    md_start = (state == IDLE) && hz.MdValidE;
    md_done  = (state == BUSY) && (cnt == 4'd1);
    md_stall = md_start || ((state == BUSY) && (cnt != 4'd1));
  end

  // mdStall dominates: while it is high, branch and load-use are masked.
  always_comb begin
    hz.StallE   = md_stall;
    hz.StallF   = md_stall | (lw_stall & ~hz.PCSrcE);
    hz.StallD   = md_stall | (lw_stall & ~hz.PCSrcE);
    hz.FlushD   = hz.PCSrcE & ~md_stall;
    hz.FlushE   = ~md_stall & (hz.PCSrcE | lw_stall);
    hz.MdStartE = md_start;
    hz.MdDoneE  = md_done;
    hz.MdBusyE  = (state == BUSY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (hz.MdValidE) begin
            state <= BUSY;
            cnt   <= CNT_START;
          end
        end
        BUSY: begin
          // MdValidE is ignored here; the op always runs to completion.
          if (cnt == 4'd1) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by
// random stimulus compared against a cycle-phase reference model.
module tb_hazard_unit;
  localparam int L = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   phase = -1;  // -1 idle, else cycles of the current op already elapsed

  always #5 clk = ~clk;

  hazard_unit_if hz ();

  hazard_unit #(.MD_LATENCY(L)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz.slave)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  task automatic zero_inputs();
    hz.rs1D = '0; hz.rs2D = '0; hz.rs1E = '0; hz.rs2E = '0; hz.rdE = '0;
    hz.ResultSrcE = '0; hz.PCSrcE = 1'b0; hz.MdValidE = 1'b0;
    hz.rdM = '0; hz.RegWriteM = 1'b0; hz.rdW = '0; hz.RegWriteW = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (hz.RegWriteM && hz.rdM != 0 && hz.rdM == rs) return 2'd2;
    if (hz.RegWriteW && hz.rdW != 0 && hz.rdW == rs) return 2'd1;
    return 2'd0;
  endfunction

  initial begin
    logic e_lw, e_md, e_start, e_done, e_busy;
    int   k;

    // reset held low with all inputs zero: everything reads 0
    zero_inputs();
    #12;
    chk("rst_fwdA", hz.ForwardAE, 2'd0);
    chk("rst_fwdB", hz.ForwardBE, 2'd0);
    chk("rst_stallF", {1'b0, hz.StallF}, 2'd0);
    chk("rst_stallE", {1'b0, hz.StallE}, 2'd0);
    chk("rst_flushE", {1'b0, hz.FlushE}, 2'd0);
    chk("rst_busy", {1'b0, hz.MdBusyE}, 2'd0);
    chk("rst_start", {1'b0, hz.MdStartE}, 2'd0);
    reset = 1'b1;
    step();

    // forwarding priority
    hz.RegWriteM = 1; hz.rdM = 5; hz.RegWriteW = 1; hz.rdW = 5; hz.rs1E = 5;
    #1 chk("fwd_m_prio", hz.ForwardAE, 2'b10);
    hz.rdM = 0;
    #1 chk("fwd_w", hz.ForwardAE, 2'b01);
    hz.rdW = 0;
    #1 chk("fwd_none", hz.ForwardAE, 2'b00);
    zero_inputs();

    // load-use
    hz.ResultSrcE = 2'b01; hz.rdE = 3; hz.rs2D = 3;
    #1;
    chk("lu_stallF", {1'b0, hz.StallF}, 2'd1);
    chk("lu_stallD", {1'b0, hz.StallD}, 2'd1);
    chk("lu_flushE", {1'b0, hz.FlushE}, 2'd1);
    chk("lu_flushD", {1'b0, hz.FlushD}, 2'd0);
    // branch wins over load-use
    hz.PCSrcE = 1;
    #1;
    chk("br_flushD", {1'b0, hz.FlushD}, 2'd1);
    chk("br_flushE", {1'b0, hz.FlushE}, 2'd1);
    chk("br_stallF", {1'b0, hz.StallF}, 2'd0);
    chk("br_stallD", {1'b0, hz.StallD}, 2'd0);
    hz.PCSrcE = 0; hz.rdE = 0;
    #1;
    chk("lu_x0_stallF", {1'b0, hz.StallF}, 2'd0);
    chk("lu_x0_flushE", {1'b0, hz.FlushE}, 2'd0);
    zero_inputs();
    step();

    // single op; MdValidE dropped in cycle 1 with a branch injected
    hz.MdValidE = 1;
    @(negedge clk);
    chk("md0_start", {1'b0, hz.MdStartE}, 2'd1);
    chk("md0_stallE", {1'b0, hz.StallE}, 2'd1);
    chk("md0_busy", {1'b0, hz.MdBusyE}, 2'd0);
    step();
    hz.MdValidE = 0; hz.PCSrcE = 1;
    @(negedge clk);
    chk("md1_busy", {1'b0, hz.MdBusyE}, 2'd1);
    chk("md1_stallE", {1'b0, hz.StallE}, 2'd1);
    chk("md1_flushD", {1'b0, hz.FlushD}, 2'd0);
    chk("md1_flushE", {1'b0, hz.FlushE}, 2'd0);
    chk("md1_start", {1'b0, hz.MdStartE}, 2'd0);
    step();
    hz.PCSrcE = 0;
    @(negedge clk);
    chk("md2_stallE", {1'b0, hz.StallE}, 2'd1);
    step();
    @(negedge clk);
    chk("md3_done", {1'b0, hz.MdDoneE}, 2'd1);
    chk("md3_stallE", {1'b0, hz.StallE}, 2'd0);
    step();
    @(negedge clk);
    chk("md4_busy", {1'b0, hz.MdBusyE}, 2'd0);
    chk("md4_done", {1'b0, hz.MdDoneE}, 2'd0);
    step();

    // back-to-back ops
    hz.MdValidE = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_start_c%0d", c), {1'b0, hz.MdStartE}, {1'b0, (c % L) == 0});
      chk($sformatf("b2b_done_c%0d", c), {1'b0, hz.MdDoneE}, {1'b0, (c % L) == L - 1});
      step();
    end
    hz.MdValidE = 0;
    step();

    // asynchronous reset abort in cycle 2 of an op
    hz.MdValidE = 1;
    step();
    hz.MdValidE = 0;
    step();
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {1'b0, hz.MdBusyE}, 2'd0);
    chk("abort_stallE", {1'b0, hz.StallE}, 2'd0);
    chk("abort_done", {1'b0, hz.MdDoneE}, 2'd0);
    step();
    #2 reset = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_abort_busy", {1'b0, hz.MdBusyE}, 2'd0);
      chk("post_abort_done", {1'b0, hz.MdDoneE}, 2'd0);
      step();
    end

    // random stimulus against the reference model
    phase = -1;
    for (int n = 0; n < 500; n++) begin
      hz.rs1D = 5'($urandom_range(0, 3)); hz.rs2D = 5'($urandom_range(0, 3));
      hz.rs1E = 5'($urandom_range(0, 3)); hz.rs2E = 5'($urandom_range(0, 3));
      hz.rdE  = 5'($urandom_range(0, 3)); hz.ResultSrcE = 2'($urandom_range(0, 3));
      hz.rdM  = 5'($urandom_range(0, 3)); hz.RegWriteM = 1'($urandom_range(0, 1));
      hz.rdW  = 5'($urandom_range(0, 3)); hz.RegWriteW = 1'($urandom_range(0, 1));
      hz.MdValidE = ($urandom_range(0, 5) == 0);
      hz.PCSrcE = hz.MdValidE ? 1'b0 : ($urandom_range(0, 4) == 0);
      @(negedge clk);
      k = (phase < 0) ? (hz.MdValidE ? 0 : -1) : phase;
      e_md    = (k >= 0) && (k < L - 1);
      e_start = (phase < 0) && hz.MdValidE;
      e_done  = (k == L - 1);
      e_busy  = (phase >= 0);
      e_lw    = (hz.ResultSrcE == 2'b01) && (hz.rdE != 0) &&
                ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
      chk("r_fwdA", hz.ForwardAE, ref_fwd(hz.rs1E));
      chk("r_fwdB", hz.ForwardBE, ref_fwd(hz.rs2E));
      chk("r_stallF", {1'b0, hz.StallF}, {1'b0, e_md | (e_lw & ~hz.PCSrcE)});
      chk("r_stallD", {1'b0, hz.StallD}, {1'b0, e_md | (e_lw & ~hz.PCSrcE)});
      chk("r_stallE", {1'b0, hz.StallE}, {1'b0, e_md});
      chk("r_flushD", {1'b0, hz.FlushD}, {1'b0, hz.PCSrcE & ~e_md});
      chk("r_flushE", {1'b0, hz.FlushE}, {1'b0, ~e_md & (hz.PCSrcE | e_lw)});
      chk("r_start", {1'b0, hz.MdStartE}, {1'b0, e_start});
      chk("r_done", {1'b0, hz.MdDoneE}, {1'b0, e_done});
      chk("r_busy", {1'b0, hz.MdBusyE}, {1'b0, e_busy});
      phase = (k < 0 || k == L - 1) ? -1 : k + 1;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
